// File: rtl/io_port_bank.sv
// io_port_bank: table-driven bank of NPORTS write-latched 8-bit Z80 I/O port registers.
// Latency: q/wr_stb/locked update 1 clk28 after the commit edge; readback registered, 1 clk28.
// Backpressure: none; the CPU bus is never stalled, exactly one commit per CPU I/O write.
// Optional feature: define IO_PORT_BANK_READBACK_EN to build the registered read path.
module io_port_bank #(
    parameter int unsigned              NPORTS     = 4,
    parameter logic [NPORTS*16-1:0]     ADDR_MATCH = {16'h00FE, 16'h1FFD, 16'hDFFD, 16'h4000},
    parameter logic [NPORTS*16-1:0]     ADDR_MASK  = {16'h0001, 16'hFFFF, 16'hFFFF, 16'hC002},
    parameter logic [7:0]               RESET_VAL  = 8'h00,
    parameter logic [NPORTS-1:0]        LOCKABLE   = 4'b0001,
    parameter int unsigned              LOCK_BIT   = 5,
    parameter logic [NPORTS-1:0]        READABLE   = 4'b0110
) (
    input  logic                  clk28,
    input  logic                  rst_n,
    input  logic [NPORTS-1:0]     en,
    input  logic                  ioreq,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [15:0]           a,
    input  logic [7:0]            d_in,
    input  logic [NPORTS-1:0]     lock_override,
    output logic [NPORTS*8-1:0]   q,
    output logic [NPORTS-1:0]     wr_stb,
    output logic [NPORTS-1:0]     locked,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    // ------------------------------------------------------------------
    // Address decode: per-port masked compare, then lowest-index winner.
    // ------------------------------------------------------------------
    logic [NPORTS-1:0] hit;
    logic [NPORTS-1:0] sel_oh;
    logic              sel_found;

    // Masked address match per port, gated by the per-port enable
    always_comb begin
        hit = '0;
        for (int i = 0; i < NPORTS; i++) begin
            hit[i] = en[i] &&
                     ((a & ADDR_MASK[i*16 +: 16]) ==
                      (ADDR_MATCH[i*16 +: 16] & ADDR_MASK[i*16 +: 16]));
        end
    end

    // Priority pick: only the lowest-index hit is ever written or read
    always_comb begin
        sel_oh    = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (hit[i] && !sel_found) begin
                sel_oh[i] = 1'b1;
                sel_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write commit: rising edge of ioreq&&wr, sampled on clk28.
    // wr_prev resets high so a write still asserted when reset releases
    // has to drop and rise again before it can commit.
    // ------------------------------------------------------------------
    logic              wr_cyc;
    logic              wr_prev;
    logic              commit;
    logic [NPORTS-1:0] wr_ok;

    assign wr_cyc = ioreq & wr;
    assign commit = wr_cyc & ~wr_prev;

    // Remember last cycle's write request for edge detection
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev <= 1'b1;
        end else begin
            wr_prev <= wr_cyc;
        end
    end

    // A commit lands on the selected port unless it is locked without override
    assign wr_ok = {NPORTS{commit}} & sel_oh & (~LOCKABLE | ~locked | lock_override);

    // One-clock write strobe per permitted commit
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_stb <= '0;
        end else begin
            wr_stb <= wr_ok;
        end
    end

    // ------------------------------------------------------------------
    // Port registers and lock bits
    // ------------------------------------------------------------------
    logic [7:0] q_r    [NPORTS];
    logic       lock_r [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_port

        // Latch CPU data into this port on a permitted commit
        always_ff @(posedge clk28 or negedge rst_n) begin
            if (!rst_n) begin
                q_r[i] <= RESET_VAL;
            end else if (wr_ok[i]) begin
                q_r[i] <= d_in;
            end
        end

        if (LOCKABLE[i]) begin : g_lock
            // Lock follows the lock bit of every permitted write; only an
            // overridden write with the bit clear (or reset) releases it
            always_ff @(posedge clk28 or negedge rst_n) begin
                if (!rst_n) begin
                    lock_r[i] <= 1'b0;
                end else if (wr_ok[i]) begin
                    lock_r[i] <= d_in[LOCK_BIT];
                end
            end
        end else begin : g_nolock
            assign lock_r[i] = 1'b0;
        end

        assign q[i*8 +: 8] = q_r[i];
        assign locked[i]   = lock_r[i];
    end

    // ------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------
`ifdef IO_PORT_BANK_READBACK_EN
    logic       rd_act;
    logic [7:0] rd_mux;

    // Select the winning port's value; a non-readable winner blocks the read
    always_comb begin
        rd_mux = 8'hFF;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_oh[i]) begin
                rd_mux = q_r[i];
            end
        end
    end

    assign rd_act = ioreq & rd & (|(sel_oh & READABLE));

    // Register read data and drive-enable; bus idles at FF
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            d_out_active <= 1'b0;
            d_out        <= 8'hFF;
        end else begin
            d_out_active <= rd_act;
            d_out        <= rd_act ? rd_mux : 8'hFF;
        end
    end
`else
    logic unused_rd;

    assign unused_rd    = rd;
    assign d_out_active = 1'b0;
    assign d_out        = 8'hFF;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: randomized + directed check of io_port_bank against a transaction-level model.
// Latency: expects q/wr_stb/locked one clk28 after the first edge of a CPU write, reads after 1 clk28.
// Backpressure: none; the bench drives CPU bus transactions back to back.
module tb_io_port_bank;

    logic        clk28;
    logic        rst_n;
    logic [3:0]  en;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [3:0]  lock_override;
    logic [31:0] q;
    logic [3:0]  wr_stb;
    logic [3:0]  locked;
    logic [7:0]  d_out;
    logic        d_out_active;

    io_port_bank dut (
        .clk28         (clk28),
        .rst_n         (rst_n),
        .en            (en),
        .ioreq         (ioreq),
        .rd            (rd),
        .wr            (wr),
        .a             (a),
        .d_in          (d_in),
        .lock_override (lock_override),
        .q             (q),
        .wr_stb        (wr_stb),
        .locked        (locked),
        .d_out         (d_out),
        .d_out_active  (d_out_active)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    // Port table as the bank is specified (index 0 first)
    localparam logic [15:0] M_MATCH [4] = '{16'h4000, 16'hDFFD, 16'h1FFD, 16'h00FE};
    localparam logic [15:0] M_MASK  [4] = '{16'hC002, 16'hFFFF, 16'hFFFF, 16'h0001};
    localparam logic [3:0]  M_LOCKABLE = 4'b0001;
    localparam logic [3:0]  M_READABLE = 4'b0110;

    // Reference model state: port values and lock flags
    logic [7:0] m_q      [4];
    logic       m_locked [4];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_sel(input logic [15:0] addr, input logic [3:0] e);
        for (int i = 0; i < 4; i++) begin
            if (e[i] && (((addr ^ M_MATCH[i]) & M_MASK[i]) == 16'h0000)) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pack_q();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_q[i];
        return r;
    endfunction

    function automatic logic [31:0] pack_locked();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = m_locked[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i]      = 8'h00;
            m_locked[i] = 1'b0;
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] stb);
        chk({tag, "_wr_stb"}, {28'h0, wr_stb}, {28'h0, stb});
        chk({tag, "_q"}, q, pack_q());
        chk({tag, "_locked"}, {28'h0, locked}, pack_locked());
    endtask

    // One CPU I/O write held for ncyc clk28 cycles; commits once on its first edge
    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data,
                             input int ncyc, input bit wobble);
        int         s;
        bit         ok;
        logic [3:0] stb;
        @(negedge clk28);
        a = addr; d_in = data; ioreq = 1'b1; wr = 1'b1; rd = 1'b0;
        s  = m_sel(addr, en);
        ok = (s >= 0) && (!M_LOCKABLE[s] || !m_locked[s] || lock_override[s]);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk28);
            stb = 4'h0;
            if (c == 0 && ok) begin
                m_q[s] = data;
                if (M_LOCKABLE[s]) m_locked[s] = data[5];
                stb = 4'(1 << s);
            end
            check_state("wr", stb);
            if (wobble) begin
                a    = 16'($urandom);
                en   = 4'($urandom);
                d_in = 8'($urandom);
            end
        end
        ioreq = 1'b0; wr = 1'b0;
        @(negedge clk28);
        check_state("wr_end", 4'h0);
    endtask

    // One single-cycle CPU I/O read
    task automatic cpu_read(input logic [15:0] addr);
        int         s;
        bit         act;
        logic [7:0] dat;
        @(negedge clk28);
        a = addr; ioreq = 1'b1; rd = 1'b1; wr = 1'b0;
        s = m_sel(addr, en);
`ifdef IO_PORT_BANK_READBACK_EN
        act = (s >= 0) && M_READABLE[s];
`else
        act = 1'b0;
`endif
        dat = act ? m_q[s] : 8'hFF;
        @(negedge clk28);
        chk("rd_active", {31'h0, d_out_active}, {31'h0, act});
        chk("rd_data", {24'h0, d_out}, {24'h0, dat});
        ioreq = 1'b0; rd = 1'b0;
        @(negedge clk28);
        chk("rd_idle_active", {31'h0, d_out_active}, 32'h0);
        chk("rd_idle_data", {24'h0, d_out}, 32'hFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addr;
        rst_n = 1'b0; ioreq = 1'b0; rd = 1'b0; wr = 1'b0;
        a = 16'h0000; d_in = 8'h00; en = 4'hF; lock_override = 4'h0;
        m_reset();

        // Reset state
        repeat (2) @(negedge clk28);
        check_state("rst", 4'h0);
        chk("rst_d_out_active", {31'h0, d_out_active}, 32'h0);
        chk("rst_d_out", {24'h0, d_out}, 32'hFF);
        rst_n = 1'b1;

        // Long write commits once
        cpu_write(16'h7FFD, 8'h17, 10, 1'b0);

        // Lock, blocked write, overridden write
        cpu_write(16'h7FFD, 8'h20, 3, 1'b0);
        cpu_write(16'h7FFD, 8'h05, 3, 1'b0);
        lock_override = 4'b0001;
        cpu_write(16'h7FFD, 8'h05, 3, 1'b0);
        lock_override = 4'h0;

        // Readback of readable and non-readable ports
        cpu_write(16'hDFFD, 8'hA5, 2, 1'b0);
        cpu_read(16'hDFFD);
        cpu_read(16'h7FFD);

        // Decode enable
        en = 4'b0111;
        cpu_write(16'h00FE, 8'h07, 2, 1'b0);
        en = 4'hF;
        cpu_write(16'h00FE, 8'h07, 2, 1'b0);

        // Reset mid-write, release with write still asserted
        @(negedge clk28);
        a = 16'h1FFD; d_in = 8'h04; ioreq = 1'b1; wr = 1'b1;
        @(negedge clk28);
        m_q[2] = 8'h04;
        check_state("pre_rst", 4'b0100);
        #2 rst_n = 1'b0;
        #1 m_reset();
        check_state("async_rst", 4'h0);
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk28);
            check_state("held_wr", 4'h0);
        end
        ioreq = 1'b0; wr = 1'b0;
        cpu_write(16'h1FFD, 8'h04, 2, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: addr = 16'h7FFD;
                1: addr = 16'hDFFD;
                2: addr = 16'h1FFD;
                3: addr = 16'h00FE;
                4: addr = 16'($urandom) & 16'hFFFE;
                default: addr = 16'($urandom);
            endcase
            en            = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            lock_override = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 2) == 0) begin
                cpu_read(addr);
            end else begin
                cpu_write(addr, 8'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
